serial_subtractor: RTL and testbench

//   Bit-serial two's-complement subtractor: diff = a - b - b_in, one bit per clock, LSB first.

---
 rtl/serial_subtractor.sv | 135 +++++++++++++
 tb/tb_serial_subtractor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - b_in, LSB first, one bit per clock.
// start/done handshake; results hold until the next operation completes.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    count;
    logic             borrow;
    logic             borrow_next;
    logic             x_bit;
    logic             y_bit;
    logic             d_bit;
    logic             accept;
    logic             last_bit;

    // One full-subtractor slice applied to the current LSBs of the operand shift registers
    always_comb begin
        x_bit       = a_sr[0];
        y_bit       = b_sr[0];
        d_bit       = x_bit ^ y_bit ^ borrow;
        borrow_next = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & borrow);
        accept      = start && ((state == IDLE) || (state == DONE));
        last_bit    = (state == RUN) && (count == LAST);
    end

    // Partial result lives apart from diff so intermediate bits never reach the outputs
    generate
        if (WIDTH == 1) begin : g_narrow
            assign res_next = d_bit;
        end else begin : g_wide
            logic [WIDTH-2:0] acc;

            always_ff @(posedge clk) begin
                if (rst) begin
                    acc <= '0;
                end else if (state == RUN) begin
                    acc <= res_next[WIDTH-1:1];
                end
            end

            assign res_next = {d_bit, acc};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count == LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = start ? RUN : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // On the last bit, the borrow still held is the borrow into the MSB, so ovf falls out directly
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            borrow <= 1'b0;
            count  <= '0;
            diff   <= '0;
            b_out  <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= b_in;
            count  <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            borrow <= borrow_next;
            if (last_bit) begin
                diff  <= res_next;
                b_out <= borrow_next;
                ovf   <= borrow ^ borrow_next;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    busy_done_exclusive: assert property (@(posedge clk) disable iff (rst) !(busy && done));
    done_single_pulse:   assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH 8, 1 and 16: expected results are queued
// at drive time from an arithmetic model and compared whenever a done pulse is seen.
module tb_serial_subtractor;

    typedef struct {
        logic [31:0] diff;
        logic        b_out;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_v;
    logic [31:0] b_v;
    logic        bin_v;
    logic [2:0]  start_v;

    logic [7:0]  diff8;
    logic        busy8, done8, bout8, ovf8;
    logic [0:0]  diff1;
    logic        busy1, done1, bout1, ovf1;
    logic [15:0] diff16;
    logic        busy16, done16, bout16, ovf16;

    int   widths[3] = '{8, 1, 16};
    int   busy_cnt[3];
    int   cycle_count = 0;
    int   num_checks = 0;
    int   num_fails = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[7:0]), .b(b_v[7:0]), .b_in(bin_v),
        .busy(busy8), .done(done8), .diff(diff8), .b_out(bout8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[0:0]), .b(b_v[0:0]), .b_in(bin_v),
        .busy(busy1), .done(done1), .diff(diff1), .b_out(bout1), .ovf(ovf1)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[15:0]), .b(b_v[15:0]), .b_in(bin_v),
        .busy(busy16), .done(done16), .diff(diff16), .b_out(bout16), .ovf(ovf16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_count <= cycle_count + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cycle_count);
        end
    endtask

    // Arithmetic reference: borrows come from signed wide subtraction, not a bit loop
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic bin, input int cyc);
        exp_t   e;
        longint m    = (longint'(1) << w) - 1;
        longint lm   = (longint'(1) << (w - 1)) - 1;
        longint full = (longint'(a) & m) - (longint'(b) & m) - longint'(bin);
        longint low  = (longint'(a) & lm) - (longint'(b) & lm) - longint'(bin);
        e.diff  = 32'(full & m);
        e.b_out = (full < 0);
        e.ovf   = (low < 0) ^ (full < 0);
        e.cyc   = cyc;
        return e;
    endfunction

    task automatic sbPush(input int idx, input exp_t e);
        case (idx)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int sbSize(input int idx);
        case (idx)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t sbPop(input int idx);
        case (idx)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic sampleInst(input int idx, input logic [31:0] d, input logic bo, input logic ov,
                              input logic bz, input logic dn);
        exp_t  e;
        string p;
        p = $sformatf("w%0d_", widths[idx]);
        if (bz) busy_cnt[idx]++;
        if (dn) begin
            checkOutput({p, "busy_with_done"}, 32'(bz), 32'd0);
            if (sbSize(idx) == 0) begin
                checkOutput({p, "spurious_done"}, 32'd1, 32'd0);
            end else begin
                e = sbPop(idx);
                checkOutput({p, "diff"}, d, e.diff);
                checkOutput({p, "b_out"}, 32'(bo), 32'(e.b_out));
                checkOutput({p, "ovf"}, 32'(ov), 32'(e.ovf));
                checkOutput({p, "done_cycle"}, 32'(cycle_count), 32'(e.cyc));
                checkOutput({p, "busy_cycles"}, 32'(busy_cnt[idx]), 32'(widths[idx]));
            end
            busy_cnt[idx] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            sampleInst(0, 32'(diff8), bout8, ovf8, busy8, done8);
            sampleInst(1, 32'(diff1), bout1, ovf1, busy1, done1);
            sampleInst(2, 32'(diff16), bout16, ovf16, busy16, done16);
        end
    end

    // Called at a negedge; the following posedge accepts, done lands WIDTH cycles later
    task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b,
                                 input logic bin);
        a_v          = a;
        b_v          = b;
        bin_v        = bin;
        start_v[idx] = 1'b1;
        sbPush(idx, model(widths[idx], a, b, bin, cycle_count + 1 + widths[idx]));
    endtask

    task automatic runOp(input int idx, input logic [31:0] a, input logic [31:0] b, input logic bin);
        @(negedge clk);
        applyStimulus(idx, a, b, bin);
        @(negedge clk);
        start_v[idx] = 1'b0;
        repeat (widths[idx] + 2) @(negedge clk);
    endtask

    // start stays high across operations, with an occasional idle gap
    task automatic randomOps(input int idx, input int n);
        int w;
        w = widths[idx];
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            applyStimulus(idx, $urandom, $urandom, 1'($urandom_range(0, 1)));
            @(posedge clk);
            repeat (w) @(posedge clk);
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                start_v[idx] = 1'b0;
                @(negedge clk);
            end
        end
        start_v[idx] = 1'b0;
        repeat (w + 3) @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        start_v = '0;
        a_v     = '0;
        b_v     = '0;
        bin_v   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_diff", 32'(diff8), 32'd0);
        checkOutput("reset_b_out", 32'(bout8), 32'd0);
        checkOutput("reset_ovf", 32'(ovf8), 32'd0);
        checkOutput("reset_busy", 32'(busy8), 32'd0);
        checkOutput("reset_done", 32'(done8), 32'd0);
        checkOutput("reset_diff16", 32'(diff16), 32'd0);
        rst = 1'b0;

        runOp(0, 32'h05, 32'h03, 1'b0);
        runOp(0, 32'h00, 32'h01, 1'b0);
        runOp(0, 32'h00, 32'h00, 1'b1);
        runOp(0, 32'h80, 32'h01, 1'b0);
        runOp(0, 32'h7F, 32'hFF, 1'b0);
        runOp(1, 32'h0, 32'h1, 1'b0);
        runOp(1, 32'h1, 32'h0, 1'b1);
        runOp(2, 32'h0000, 32'h0001, 1'b0);

        // Reset two cycles into a run: outputs clear and the aborted op never completes
        @(negedge clk);
        applyStimulus(0, 32'h5A, 32'h33, 1'b1);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("midrun_reset_diff", 32'(diff8), 32'd0);
        checkOutput("midrun_reset_b_out", 32'(bout8), 32'd0);
        checkOutput("midrun_reset_ovf", 32'(ovf8), 32'd0);
        checkOutput("midrun_reset_busy", 32'(busy8), 32'd0);
        checkOutput("midrun_reset_done", 32'(done8), 32'd0);
        q0.delete();
        for (int i = 0; i < 3; i++) busy_cnt[i] = 0;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        runOp(0, 32'h05, 32'h03, 1'b0);

        // A start pulse mid-run must not disturb the operation in flight
        @(negedge clk);
        applyStimulus(0, 32'h05, 32'h03, 1'b0);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        a_v        = 32'hFF;
        b_v        = 32'h11;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (8) @(negedge clk);

        randomOps(0, 1000);
        randomOps(1, 1000);
        randomOps(2, 1000);

        checkOutput("w8_pending_results", 32'(q0.size()), 32'd0);
        checkOutput("w1_pending_results", 32'(q1.size()), 32'd0);
        checkOutput("w16_pending_results", 32'(q2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
